lcd_bus_scheduler: RTL

//  Owns the HD44780-style 16x2 character LCD bus and sequences every transfer on it.

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_rr_arb2.sv | 30 +++
 rtl/lcd_bus_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types, command bytes and default timing for the LCD bus scheduler.
// Imported by the scheduler top and its round-robin arbiter.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } lcd_state_e;

    localparam logic [7:0] FUNC_8BIT_2L = 8'h38;
    localparam logic [7:0] DISP_ON      = 8'h0C;
    localparam logic [7:0] CLEAR        = 8'h01;
    localparam logic [7:0] ENTRY_INC    = 8'h06;
    localparam logic [7:0] SET_DDRAM    = 8'h80;

    localparam int T_PWRUP_DEF = 750000;
    localparam int T_SETUP_DEF = 2;
    localparam int T_EN_DEF    = 12;
    localparam int T_CMD_DEF   = 2000;
    localparam int T_CLR_DEF   = 82000;

    localparam logic [1:0] INIT_LAST = 2'd3;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] c;
        c = FUNC_8BIT_2L;
        case (idx)
            2'd0: c = FUNC_8BIT_2L;
            2'd1: c = DISP_ON;
            2'd2: c = CLEAR;
            2'd3: c = ENTRY_INC;
            default: c = FUNC_8BIT_2L;
        endcase
        return c;
    endfunction

    // Clear and home need the long execution wait.
    function automatic logic is_slow(input logic rs, input logic [7:0] data);
        return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-requester round-robin grant; the pointer flips to the other
// requester whenever a grant is taken.
module lcd_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic grant0_o,
    output logic grant1_o
);

    logic ptr_q;

    always_comb begin
        grant0_o = en_i && valid0_i && (!valid1_i || !ptr_q);
        grant1_o = en_i && valid1_i && (!valid0_i || ptr_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= 1'b0;
        end else if (grant0_o) begin
            ptr_q <= 1'b1;
        end else if (grant1_o) begin
            ptr_q <= 1'b0;
        end
    end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// HD44780 bus owner: power-up wait, init sequence, then round-robin
// sharing of the bus between two writers with EN setup/pulse/exec timing.
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int T_PWRUP = T_PWRUP_DEF,
    parameter int T_SETUP = T_SETUP_DEF,
    parameter int T_EN    = T_EN_DEF,
    parameter int T_CMD   = T_CMD_DEF,
    parameter int T_CLR   = T_CLR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] LCD_data,
    output logic       LCD_en,
    output logic       LCD_rw,
    output logic       LCD_rs,
    output logic       LCD_blon,
    output logic       init_done,
    output logic       busy
);

    localparam int CNT_MAX = (T_PWRUP > T_CLR) ? T_PWRUP : T_CLR;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LD_PWRUP = CW'(T_PWRUP - 1);
    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(T_EN - 1);
    localparam logic [CW-1:0] LD_CMD   = CW'(T_CMD - 1);
    localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR - 1);

    lcd_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    idx_q;
    logic [7:0]    data_q;
    logic          rs_q;
    logic          en_q;
    logic          done_q;
    logic          busy_q;

    logic          in_idle;
    logic          grant0;
    logic          grant1;
    logic          accept;
    logic          sel_rs_d;
    logic [7:0]    sel_data_d;
    logic          cnt_zero;

    assign in_idle  = (state_q == ST_IDLE);
    assign cnt_zero = (cnt_q == '0);

    lcd_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .en_i     (in_idle),
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .grant0_o (grant0),
        .grant1_o (grant1)
    );

    always_comb begin
        accept     = grant0 || grant1;
        sel_rs_d   = grant1 ? req1_rs : req0_rs;
        sel_data_d = grant1 ? req1_data : req0_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_PWRUP;
            cnt_q   <= LD_PWRUP;
            idx_q   <= 2'd0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_PWRUP: begin
                    if (cnt_zero) begin
                        idx_q   <= 2'd0;
                        state_q <= ST_INIT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_INIT: begin
                    rs_q    <= 1'b0;
                    data_q  <= init_cmd(idx_q);
                    cnt_q   <= LD_SETUP;
                    state_q <= ST_SETUP;
                end
                ST_IDLE: begin
                    if (accept) begin
                        rs_q    <= sel_rs_d;
                        data_q  <= sel_data_d;
                        cnt_q   <= LD_SETUP;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_zero) begin
                        en_q    <= 1'b1;
                        cnt_q   <= LD_EN;
                        state_q <= ST_PULSE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_zero) begin
                        en_q    <= 1'b0;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    cnt_q   <= is_slow(rs_q, data_q) ? LD_CLR : LD_CMD;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (!cnt_zero) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (done_q) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (idx_q == INIT_LAST) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ST_INIT;
                    end
                end
                default: begin
                    state_q <= ST_PWRUP;
                    cnt_q   <= LD_PWRUP;
                end
            endcase
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign LCD_data   = data_q;
    assign LCD_en     = en_q;
    assign LCD_rs     = rs_q;
    assign LCD_rw     = 1'b0;
    assign LCD_blon   = 1'b1;
    assign init_done  = done_q;
    assign busy       = busy_q;

endmodule
